// File: rtl/data_memory_access_unit.sv
// Byte/halfword load-store front end: splits each request into single-byte memory strobes.
// Latency accept->rsp: 2..4 cycles; ready only in IDLE, response cannot be stalled.
module data_memory_access_unit #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic                i_req_size,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [2*DATA_W-1:0] i_req_wdata,
    output logic                o_rsp_valid,
    output logic [2*DATA_W-1:0] o_rsp_rdata,
    output logic                o_busy,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic                o_mem_we,
    output logic                o_mem_re,
    input  logic [DATA_W-1:0]   i_mem_rdata
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC0 = 3'd1;
    localparam logic [2:0] S_ACC1 = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]          state_q, state_d;
    logic                we_q, size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2*DATA_W-1:0] wdata_q;
    logic [2*DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic                accept;

    assign accept = i_req_valid && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ACC0;
            S_ACC0:  state_d = size_q ? S_ACC1 : (we_q ? S_RESP : S_WAIT);
            S_ACC1:  state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port is registered, so strobes are computed for the state being entered.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        if (accept) begin
            mem_addr_d = i_req_addr;
            mem_we_d   = i_req_we;
            mem_re_d   = !i_req_we;
            if (i_req_we) mem_wdata_d = i_req_wdata[DATA_W-1:0];
        end else if (state_q == S_ACC0 && state_d == S_ACC1) begin
            mem_addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            mem_we_d   = we_q;
            mem_re_d   = !we_q;
            if (we_q) mem_wdata_d = wdata_q[2*DATA_W-1:DATA_W];
        end
    end

    // Read data trails each read strobe by one cycle.
    always_comb begin
        rdata_d = rdata_q;
        if (accept) begin
            rdata_d = '0;
        end else if (state_q == S_ACC1 && !we_q) begin
            rdata_d[DATA_W-1:0] = i_mem_rdata;
        end else if (state_q == S_WAIT) begin
            if (size_q) rdata_d[2*DATA_W-1:DATA_W] = i_mem_rdata;
            else        rdata_d[DATA_W-1:0]        = i_mem_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            if (accept) begin
                we_q    <= i_req_we;
                size_q  <= i_req_size;
                addr_q  <= i_req_addr;
                wdata_q <= i_req_wdata;
            end
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_re    = mem_re_q;
endmodule
